clock_ctrl: RTL and testbench

Front-panel sequencer for the computer's clock module. Debounces the mode, step and resume buttons, latches the CPU halt request, and drives the clock module's `select`, `mpulse` and `hlt` inputs. It runs on the fast board clock and emits clean, fixed-width manual pulses in step mode.

---
 rtl/clock_ctrl.sv | 203 ++++++++++++++++++++
 tb/tb_clock_ctrl.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/clock_ctrl.sv
// Front-panel sequencer for the clock module: debounced mode/step/resume buttons, halt latch, manual pulses.
// Define CLOCK_CTRL_BURST_EN to let one step request emit burst_len pulses.
module clock_ctrl #(
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int PULSE_WIDTH     = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       mode_btn,
   input  logic       step_btn,
   input  logic       resume_btn,
   input  logic       cpu_hlt,
   input  logic [7:0] burst_len,
   output logic       select,
   output logic       mpulse,
   output logic       hlt,
   output logic       busy,
   output logic [7:0] step_cnt
);

   localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam int TW = (PULSE_WIDTH > 1) ? $clog2(PULSE_WIDTH) : 1;
   localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);
   localparam logic [TW-1:0] PW_LAST = TW'(PULSE_WIDTH - 1);

   typedef enum logic [2:0] {
      S_RUN,
      S_STEP_IDLE,
      S_PULSE_HI,
      S_PULSE_LO,
      S_HALTED
   } state_t;

   logic [2:0]    btn_raw;
   logic [2:0]    sync_p0;
   logic [2:0]    sync_p1;
   logic [2:0]    db_lvl;
   logic [2:0]    btn_evt;
   logic [CW-1:0] db_cnt [3];
   logic          hlt_q;
   logic          hlt_edge;
   logic          mode_evt;
   logic          step_evt;
   logic          resume_evt;

   state_t        state;
   state_t        nxt;
   logic          mode_r;
   logic          nxt_mode;
   logic [TW-1:0] tmr;
   logic          tmr_done;
   logic          hlt_pend;
   logic [7:0]    burst_rem;

   assign btn_raw    = {resume_btn, step_btn, mode_btn};
   assign mode_evt   = btn_evt[0];
   assign step_evt   = btn_evt[1];
   assign resume_evt = btn_evt[2];
   assign hlt_edge   = cpu_hlt & ~hlt_q;
   assign tmr_done   = (tmr == PW_LAST);

   // Stage p0/p1: two-flop synchronizer, then per-button stability counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_p0 <= '0;
         sync_p1 <= '0;
         db_lvl  <= '0;
         btn_evt <= '0;
         hlt_q   <= 1'b0;
         for (int i = 0; i < 3; i++) begin
            db_cnt[i] <= '0;
         end
      end else begin
         sync_p0 <= btn_raw;
         sync_p1 <= sync_p0;
         hlt_q   <= cpu_hlt;
         for (int i = 0; i < 3; i++) begin
            btn_evt[i] <= 1'b0;
            if (sync_p1[i] == db_lvl[i]) begin
               db_cnt[i] <= '0;
            end else if (db_cnt[i] == DB_LAST) begin
               // Level accepted on the Nth consecutive differing sample; only 0->1 is an event.
               db_lvl[i]  <= sync_p1[i];
               db_cnt[i]  <= '0;
               btn_evt[i] <= sync_p1[i];
            end else begin
               db_cnt[i] <= db_cnt[i] + 1'b1;
            end
         end
      end
   end

   always_comb begin
      nxt      = state;
      nxt_mode = mode_r;
      case (state)
         S_RUN: begin
            if (hlt_edge) begin
               nxt = S_HALTED;
            end else if (mode_evt) begin
               nxt      = S_STEP_IDLE;
               nxt_mode = 1'b0;
            end
         end
         S_STEP_IDLE: begin
            if (hlt_edge) begin
               nxt = S_HALTED;
            end else if (mode_evt) begin
               nxt      = S_RUN;
               nxt_mode = 1'b1;
            end else if (step_evt) begin
               nxt = S_PULSE_HI;
            end
         end
         S_PULSE_HI: begin
            // A halt seen during the high phase waits for the pulse to finish.
            if (tmr_done) begin
               nxt = (hlt_pend || hlt_edge) ? S_HALTED : S_PULSE_LO;
            end
         end
         S_PULSE_LO: begin
            if (hlt_edge) begin
               nxt = S_HALTED;
            end else if (tmr_done) begin
               if (burst_rem != 8'd0) begin
                  nxt = S_PULSE_HI;
               end else if (hlt_pend) begin
                  nxt = S_HALTED;
               end else begin
                  nxt = S_STEP_IDLE;
               end
            end
         end
         S_HALTED: begin
            if (mode_evt) begin
               nxt_mode = ~mode_r;
            end
            if (resume_evt) begin
               nxt = nxt_mode ? S_RUN : S_STEP_IDLE;
            end
         end
         default: nxt = S_STEP_IDLE;
      endcase
   end

   // Stage p2: state and registered outputs, all derived from the next state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= S_STEP_IDLE;
         mode_r   <= 1'b0;
         select   <= 1'b0;
         mpulse   <= 1'b0;
         hlt      <= 1'b0;
         busy     <= 1'b0;
         step_cnt <= 8'd0;
         tmr      <= '0;
         hlt_pend <= 1'b0;
      end else begin
         state  <= nxt;
         mode_r <= nxt_mode;
         select <= nxt_mode;
         mpulse <= (nxt == S_PULSE_HI);
         hlt    <= (nxt == S_HALTED);
         busy   <= (nxt == S_PULSE_HI) || (nxt == S_PULSE_LO);

         if ((nxt != state) || !((state == S_PULSE_HI) || (state == S_PULSE_LO))) begin
            tmr <= '0;
         end else begin
            tmr <= tmr + 1'b1;
         end

         if ((nxt == S_PULSE_HI) && (state != S_PULSE_HI)) begin
            step_cnt <= step_cnt + 8'd1;
         end

         if (nxt == S_HALTED) begin
            hlt_pend <= 1'b0;
         end else if ((state == S_PULSE_HI) && hlt_edge) begin
            hlt_pend <= 1'b1;
         end
      end
   end

`ifdef CLOCK_CTRL_BURST_EN
   // Count holds pulses still owed after the one being entered, so load is len-1.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         burst_rem <= 8'd0;
      end else if (nxt == S_HALTED) begin
         burst_rem <= 8'd0;
      end else if ((state == S_STEP_IDLE) && (nxt == S_PULSE_HI)) begin
         burst_rem <= (burst_len == 8'd0) ? 8'd0 : (burst_len - 8'd1);
      end else if ((state == S_PULSE_LO) && (nxt == S_PULSE_HI)) begin
         burst_rem <= burst_rem - 8'd1;
      end
   end
`else
   logic unused_burst_len;
   assign unused_burst_len = ^burst_len;
   assign burst_rem        = 8'd0;
`endif

endmodule

// File: tb/tb_clock_ctrl.sv
// Scoreboard bench for clock_ctrl: stimulus queues expected pulses, a negedge monitor checks each one.
module tb_clock_ctrl;

   localparam int DB  = 4;
   localparam int PW  = 2;
   // Input driven in cycle c: 2 sync edges + DB debounce samples + 1 FSM edge.
   localparam int LAT = DB + 3;

   typedef struct {
      int         cyc;
      logic [7:0] cnt;
   } pulse_t;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       mode_btn;
   logic       step_btn;
   logic       resume_btn;
   logic       cpu_hlt;
   logic [7:0] burst_len;
   logic       select;
   logic       mpulse;
   logic       hlt;
   logic       busy;
   logic [7:0] step_cnt;

   int         nvec = 0;
   int         nbad = 0;
   int         cyc = 0;
   int         busy_cyc = 0;
   int         width = 0;
   logic       mp_q = 1'b0;
   logic [7:0] exp_cnt = 8'd0;
   pulse_t     exp_q[$];

   clock_ctrl #(.DEBOUNCE_CYCLES(DB), .PULSE_WIDTH(PW)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .mode_btn   (mode_btn),
      .step_btn   (step_btn),
      .resume_btn (resume_btn),
      .cpu_hlt    (cpu_hlt),
      .burst_len  (burst_len),
      .select     (select),
      .mpulse     (mpulse),
      .hlt        (hlt),
      .busy       (busy),
      .step_cnt   (step_cnt)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nbad++;
         $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic expect_pulse(input int at);
      pulse_t e;
      exp_cnt = exp_cnt + 8'd1;
      e.cyc   = at;
      e.cnt   = exp_cnt;
      exp_q.push_back(e);
   endtask

   task automatic press(input int which, input int hold);
      case (which)
         0: mode_btn = 1'b1;
         1: step_btn = 1'b1;
         default: resume_btn = 1'b1;
      endcase
      tick(hold);
      mode_btn   = 1'b0;
      step_btn   = 1'b0;
      resume_btn = 1'b0;
      tick(DB + 6);
   endtask

   task automatic step_press();
      expect_pulse(cyc + LAT);
      press(1, 8);
   endtask

   // Monitor: every rising mpulse must match the head of the expected queue
   always @(negedge clk) begin
      pulse_t e;
      if (!rst_n) begin
         mp_q = 1'b0;
      end else begin
         if (busy) busy_cyc++;
         if (mpulse && !mp_q) begin
            width = 1;
            if (exp_q.size() == 0) begin
               nvec++;
               nbad++;
               $display("FAIL unexpected_pulse: mpulse rose at cycle %0d (step_cnt %0d), none queued", cyc, step_cnt);
            end else begin
               e = exp_q.pop_front();
               chk("pulse_cycle", cyc, e.cyc);
               chk("pulse_step_cnt", {24'd0, step_cnt}, {24'd0, e.cnt});
               chk("pulse_busy", {31'd0, busy}, 32'd1);
            end
         end else if (mpulse) begin
            width++;
         end
         if (!mpulse && mp_q) chk("pulse_width", width, PW);
         mp_q = mpulse;
      end
   end

   initial begin
      int c;
      int b0;
      rst_n      = 1'b0;
      mode_btn   = 1'b0;
      step_btn   = 1'b0;
      resume_btn = 1'b0;
      cpu_hlt    = 1'b0;
      burst_len  = 8'd1;
      tick(3);
      chk("rst_select", {31'd0, select}, 32'd0);
      chk("rst_mpulse", {31'd0, mpulse}, 32'd0);
      chk("rst_hlt", {31'd0, hlt}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_step_cnt", {24'd0, step_cnt}, 32'd0);
      rst_n = 1'b1;
      tick(2);

      // Single step from reset
      b0 = busy_cyc;
      expect_pulse(cyc + LAT);
      press(1, 10);
      chk("step1_cnt", {24'd0, step_cnt}, 32'd1);
      chk("step1_busy_len", busy_cyc - b0, 2 * PW);
      chk("step1_select", {31'd0, select}, 32'd0);

      // Bouncing contact never stays stable for DB samples
      for (int i = 0; i < 10; i++) begin
         step_btn = ~step_btn;
         tick(2);
      end
      step_btn = 1'b0;
      tick(12);
      chk("bounce_cnt", {24'd0, step_cnt}, 32'd1);

      // Mode toggle: RUN ignores steps
      press(0, 8);
      chk("mode_run_select", {31'd0, select}, 32'd1);
      press(1, 8);
      chk("run_step_ignored", {24'd0, step_cnt}, 32'd1);
      press(0, 8);
      chk("mode_step_select", {31'd0, select}, 32'd0);

      // Halt raised on the first high cycle of a pulse
      c = cyc;
      expect_pulse(c + LAT);
      step_btn = 1'b1;
      tick(LAT);
      cpu_hlt  = 1'b1;
      step_btn = 1'b0;
      chk("hmid_mpulse_0", {31'd0, mpulse}, 32'd1);
      tick(1);
      chk("hmid_mpulse_1", {31'd0, mpulse}, 32'd1);
      chk("hmid_hlt_1", {31'd0, hlt}, 32'd0);
      tick(1);
      chk("hmid_mpulse_2", {31'd0, mpulse}, 32'd0);
      chk("hmid_hlt_2", {31'd0, hlt}, 32'd1);
      chk("hmid_busy_2", {31'd0, busy}, 32'd0);
      tick(10);
      press(2, 8);
      chk("resume_hlt", {31'd0, hlt}, 32'd0);
      chk("resume_select", {31'd0, select}, 32'd0);
      step_press();
      chk("resume_step_cnt", {24'd0, step_cnt}, 32'd3);
      cpu_hlt = 1'b0;
      tick(2);

      // Burst request
      burst_len = 8'd3;
      b0 = busy_cyc;
      c = cyc;
`ifdef CLOCK_CTRL_BURST_EN
      expect_pulse(c + LAT);
      expect_pulse(c + LAT + 2 * PW);
      expect_pulse(c + LAT + 4 * PW);
      press(1, 8);
      tick(12);
      chk("burst_cnt", {24'd0, step_cnt}, 32'd6);
      chk("burst_busy_len", busy_cyc - b0, 6 * PW);
`else
      expect_pulse(c + LAT);
      press(1, 8);
      tick(12);
      chk("burst_cnt", {24'd0, step_cnt}, 32'd4);
      chk("burst_busy_len", busy_cyc - b0, 2 * PW);
`endif
      burst_len = 8'd1;

      // Reset asserted in the middle of a pulse
      expect_pulse(cyc + LAT);
      step_btn = 1'b1;
      tick(LAT + 1);
      chk("rmid_mpulse_before", {31'd0, mpulse}, 32'd1);
      rst_n    = 1'b0;
      step_btn = 1'b0;
      #1;
      chk("rmid_mpulse_after", {31'd0, mpulse}, 32'd0);
      chk("rmid_step_cnt", {24'd0, step_cnt}, 32'd0);
      exp_cnt = 8'd0;
      tick(2);
      rst_n = 1'b1;
      tick(3);

      // 255 pulses, then one more wraps to zero
      for (int i = 0; i < 255; i++) step_press();
      chk("wrap_255", {24'd0, step_cnt}, 32'd255);
      step_press();
      chk("wrap_0", {24'd0, step_cnt}, 32'd0);

      // Mode and step in the same cycle: mode wins, no pulse
      mode_btn = 1'b1;
      step_btn = 1'b1;
      tick(8);
      mode_btn = 1'b0;
      step_btn = 1'b0;
      tick(DB + 6);
      chk("prio_select", {31'd0, select}, 32'd1);
      chk("prio_step_cnt", {24'd0, step_cnt}, 32'd0);

      // Halt from RUN takes one cycle; resume returns to RUN
      cpu_hlt = 1'b1;
      chk("run_hlt_before", {31'd0, hlt}, 32'd0);
      tick(1);
      chk("run_hlt_after", {31'd0, hlt}, 32'd1);
      tick(3);
      press(2, 8);
      chk("run_resume_hlt", {31'd0, hlt}, 32'd0);
      chk("run_resume_select", {31'd0, select}, 32'd1);
      cpu_hlt = 1'b0;
      tick(4);

      chk("pulses_outstanding", exp_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
      $finish;
   end

endmodule
